// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/HALT control for the PC, next-PC mux, IR and memory port.
// Optional macro PC_SEQ_WDOG_EN adds a memory-wait watchdog that forces HALT and raises a sticky fault.
module pc_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        comp,
  input  logic        stall,
  input  logic        mem_ready,
  output logic [2:0]  pcSrc,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        mem_req,
  output logic        mem_we,
  output logic        link_write,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [15:0] retired
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned SRC_W  = 3;
  localparam int unsigned ST_W   = 3;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [ST_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [OP_W-1:0] OP_LD   = 4'h6;
  localparam logic [OP_W-1:0] OP_ST   = 4'h7;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h8;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h9;
  localparam logic [OP_W-1:0] OP_J    = 4'hA;
  localparam logic [OP_W-1:0] OP_JAL  = 4'hB;
  localparam logic [OP_W-1:0] OP_JR   = 4'hC;
  localparam logic [OP_W-1:0] OP_JM   = 4'hD;
  localparam logic [OP_W-1:0] OP_JMR  = 4'hE;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [SRC_W-1:0] SRC_SEQ    = 3'b000;
  localparam logic [SRC_W-1:0] SRC_BRANCH = 3'b001;
  localparam logic [SRC_W-1:0] SRC_JUMP   = 3'b010;
  localparam logic [SRC_W-1:0] SRC_REG    = 3'b011;
  localparam logic [SRC_W-1:0] SRC_MEMIND = 3'b100;
  localparam logic [SRC_W-1:0] SRC_MEMREG = 3'b101;

  if ((MEM_TIMEOUT < 2) || (MEM_TIMEOUT > 255)) begin : g_bad_timeout
    $error("pc_sequencer: MEM_TIMEOUT must be within 2..255");
  end

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_retired;
  logic [SRC_W-1:0]    w_pc_src;
  logic                w_pc_write;
  logic                w_ir_write;
  logic                w_mem_req;
  logic                w_mem_we;
  logic                w_link;
  logic                w_quiet;
  logic                w_pc_write_g;
  logic                w_enter_halt;

`ifdef PC_SEQ_WDOG_EN
  logic [WAIT_W-1:0]   r_wait;
  logic                r_fault;
  logic                w_waiting;
  logic                w_timeout;

  // A waiting cycle is an unstalled FETCH/MEM cycle with no memory response.
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready && !stall;
  assign w_timeout = w_waiting &&
                     (({1'b0, r_wait} + (WAIT_W+1)'(1)) >= (WAIT_W+1)'(MEM_TIMEOUT));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_timeout) r_fault <= 1'b1;
      if (!stall) r_wait <= w_waiting ? (r_wait + WAIT_W'(1)) : '0;
    end
  end

  assign fault = r_fault;
`else
  assign fault = 1'b0;
`endif

  // Next-state and raw strobe decode.
  always_comb begin
    w_next     = r_state;
    w_pc_src   = SRC_SEQ;
    w_pc_write = 1'b0;
    w_ir_write = 1'b0;
    w_mem_req  = 1'b0;
    w_mem_we   = 1'b0;
    w_link     = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ready) begin
          w_ir_write = 1'b1;
          w_next     = S_DECODE;
        end
      end
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        w_next     = S_FETCH;
        w_pc_write = 1'b1;
        case (opcode)
          OP_LD, OP_ST: begin
            w_pc_write = 1'b0;
            w_next     = S_MEM;
          end
          OP_BEQ:  w_pc_src = comp ? SRC_BRANCH : SRC_SEQ;
          OP_BNE:  w_pc_src = comp ? SRC_SEQ : SRC_BRANCH;
          OP_J:    w_pc_src = SRC_JUMP;
          OP_JAL: begin
            w_pc_src = SRC_JUMP;
            w_link   = 1'b1;
          end
          OP_JR:   w_pc_src = SRC_REG;
          OP_JM:   w_pc_src = SRC_MEMIND;
          OP_JMR:  w_pc_src = SRC_MEMREG;
          OP_HALT: begin
            w_pc_write = 1'b0;
            w_next     = S_HALT;
          end
          default: w_pc_src = SRC_SEQ;
        endcase
      end
      S_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (opcode == OP_ST);
        if (mem_ready) begin
          w_pc_write = 1'b1;
          w_next     = S_FETCH;
        end
      end
      S_HALT: w_next = S_HALT;
      default: w_next = S_HALT;
    endcase
`ifdef PC_SEQ_WDOG_EN
    if (w_timeout) w_next = S_HALT;
`endif
    if (stall) w_next = r_state;
  end

  assign w_quiet      = reset | stall;
  assign w_pc_write_g = w_pc_write & ~w_quiet;
  assign w_enter_halt = (w_next == S_HALT) && (r_state != S_HALT) && !w_quiet;

  // State register and retired-instruction counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_pc_write_g || w_enter_halt) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign pcSrc      = w_pc_src;
  assign pcWrite    = w_pc_write_g;
  assign irWrite    = w_ir_write & ~w_quiet;
  assign mem_req    = w_mem_req & ~w_quiet;
  assign mem_we     = w_mem_we & ~w_quiet;
  assign link_write = w_link & ~w_quiet;
  assign halted     = (r_state == S_HALT);
  assign state      = ST_W'(r_state);
  assign retired    = r_retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus predicts strobe events from the instruction-level timing rules,
// a monitor pops and compares them whenever the sequencer emits irWrite, pcWrite or enters HALT.
`timescale 1ns/1ps
module tb_pc_sequencer;

  localparam int unsigned TIMEOUT = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        comp;
  logic        stall;
  logic        mem_ready;
  logic [2:0]  pcSrc;
  logic        pcWrite;
  logic        irWrite;
  logic        mem_req;
  logic        mem_we;
  logic        link_write;
  logic        halted;
  logic        fault;
  logic [2:0]  state;
  logic [15:0] retired;

  pc_sequencer #(.MEM_TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .comp(comp), .stall(stall),
    .mem_ready(mem_ready), .pcSrc(pcSrc), .pcWrite(pcWrite), .irWrite(irWrite),
    .mem_req(mem_req), .mem_we(mem_we), .link_write(link_write), .halted(halted),
    .fault(fault), .state(state), .retired(retired)
  );

  always #5 clock = ~clock;

  // kind: 0 = irWrite, 1 = pcWrite, 2 = HALT entry
  typedef struct {
    int         kind;
    int         cyc;
    logic [2:0] src;
    logic       link;
    int         we_n;
    int         ret;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  int  ref_ret = 0;
  int  we_cnt = 0;
  logic prev_halted = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference next-PC select for a non-memory instruction.
  function automatic logic [2:0] ref_src(input logic [3:0] op, input logic cp);
    case (op)
      4'h8:        return cp ? 3'd1 : 3'd0;
      4'h9:        return cp ? 3'd0 : 3'd1;
      4'hA, 4'hB:  return 3'd2;
      4'hC:        return 3'd3;
      4'hD:        return 3'd4;
      4'hE:        return 3'd5;
      default:     return 3'd0;
    endcase
  endfunction

  // Monitor: pop the predicted event whenever the DUT shows one.
  always @(negedge clock) begin
    ev_t e;
    int  kind;
    if (reset) begin
      we_cnt = 0;
    end else begin
      if (mem_we) we_cnt++;
      chk("link_only_with_pcwrite", 32'(link_write & ~pcWrite), 32'd0);
      if (irWrite || pcWrite || (halted && !prev_halted)) begin
        kind = pcWrite ? 1 : (irWrite ? 0 : 2);
        if (q.size() == 0) begin
          chk("unexpected_event_kind", 32'(kind), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("event_kind", 32'(kind), 32'(e.kind));
          chk("event_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == 1) begin
            chk("pcsrc", 32'(pcSrc), 32'(e.src));
            chk("link_write", 32'(link_write), 32'(e.link));
            chk("mem_we_cycles", 32'(we_cnt), 32'(e.we_n));
            chk("retired_at_pcwrite", 32'(retired), 32'(e.ret));
            we_cnt = 0;
          end else if (e.kind == 2 && e.ret >= 0) begin
            chk("retired_at_halt", 32'(retired), 32'(e.ret));
          end
        end
      end
    end
    prev_halted = halted;
  end

  task automatic drive(input logic mr, input logic [3:0] op, input logic cp);
    mem_ready = mr;
    opcode    = op;
    comp      = cp;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; mem_ready = 1'b1; opcode = 4'h0; comp = 1'b0;
    #1;
    chk("reset_strobes", 32'({pcWrite, irWrite, mem_req, mem_we, link_write}), 32'd0);
    @(posedge clock); #1;
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_retired", 32'(retired), 32'd0);
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_strobes_2", 32'({pcWrite, irWrite, mem_req, mem_we, link_write}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; mem_ready = 1'b0;
    ref_ret = 0;
    #1;
    chk("first_cycle_mem_req", 32'(mem_req), 32'd1);
  endtask

  // One instruction: fw fetch waits, mw MEM waits, es stalled EXEC cycles.
  task automatic run_instr(input logic [3:0] op, input logic cp, input int fw, input int mw, input int es);
    ev_t e;
    int  c0;
    int  t_exec;
    int  r0;
    bit  is_mem;
    c0     = cyc;
    t_exec = c0 + fw + 2 + es;
    is_mem = (op == 4'h6) || (op == 4'h7);
    r0     = ref_ret;
    e = '{kind: 0, cyc: c0 + fw, src: 3'd0, link: 1'b0, we_n: 0, ret: 0};
    q.push_back(e);
    if (op == 4'hF) begin
      e = '{kind: 2, cyc: t_exec + 1, src: 3'd0, link: 1'b0, we_n: 0, ret: ref_ret + 1};
    end else begin
      e = '{kind: 1, cyc: is_mem ? (t_exec + 1 + mw) : t_exec,
            src: is_mem ? 3'd0 : ref_src(op, cp), link: (op == 4'hB),
            we_n: (op == 4'h7) ? (mw + 1) : 0, ret: ref_ret};
    end
    q.push_back(e);
    ref_ret++;
    for (int i = 0; i < fw; i++) drive(1'b0, 4'($urandom), 1'($urandom));
    drive(1'b1, 4'($urandom), 1'($urandom));
    drive(1'($urandom), op, 1'($urandom));
    for (int i = 0; i < es; i++) begin
      stall = 1'b1; mem_ready = 1'($urandom); opcode = op; comp = 1'($urandom);
      #1;
      chk("stall_state", 32'(state), 32'd2);
      chk("stall_no_pcwrite", 32'(pcWrite), 32'd0);
      chk("stall_retired", 32'(retired), 32'(r0));
      @(posedge clock); #1;
    end
    stall = 1'b0;
    drive(1'($urandom), op, cp);
    if (is_mem) begin
      for (int i = 0; i < mw; i++) drive(1'b0, op, 1'($urandom));
      drive(1'b1, op, 1'($urandom));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cycles=%0d limit_ns=500000", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    ev_t e;
    int  c0;
    do_reset();

    // Back-to-back opcode 0x0 with zero-wait memory.
    for (int i = 0; i < 3; i++) run_instr(4'h0, 1'b0, 0, 0, 0);
    chk("retired_after_9", 32'(retired), 32'd3);

    // Branches and jumps.
    run_instr(4'h8, 1'b1, 0, 0, 0);
    run_instr(4'h8, 1'b0, 0, 0, 0);
    run_instr(4'h9, 1'b1, 1, 0, 0);
    run_instr(4'h9, 1'b0, 0, 0, 0);
    run_instr(4'hB, 1'b0, 0, 0, 0);
    run_instr(4'hE, 1'b1, 2, 0, 0);

    // Store with two MEM wait cycles, then load.
    run_instr(4'h7, 1'b0, 0, 2, 0);
    run_instr(4'h6, 1'b1, 1, 1, 0);

    // Stall held four cycles in EXEC.
    run_instr(4'hA, 1'b0, 0, 0, 4);

    for (int i = 0; i < 40; i++) begin
      run_instr(4'($urandom_range(0, 14)), 1'($urandom), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // HALT, then activity that must produce nothing.
    run_instr(4'hF, 1'b0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      mem_ready = 1'($urandom); opcode = 4'($urandom); comp = 1'($urandom);
      #1;
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_state", 32'(state), 32'd4);
      chk("halt_strobes", 32'({pcWrite, irWrite, mem_req, mem_we, link_write}), 32'd0);
      @(posedge clock); #1;
    end
    chk("halt_retired_hold", 32'(retired), 32'(ref_ret));

    do_reset();

    // Reset while a store waits in MEM abandons the request.
    c0 = cyc;
    e = '{kind: 0, cyc: c0, src: 3'd0, link: 1'b0, we_n: 0, ret: 0};
    q.push_back(e);
    drive(1'b1, 4'h7, 1'b0);
    drive(1'b0, 4'h7, 1'b0);
    drive(1'b0, 4'h7, 1'b0);
    mem_ready = 1'b0;
    #1;
    chk("mem_we_in_mem", 32'({mem_req, mem_we}), 32'd3);
    @(posedge clock); #1;
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    chk("midreset_strobes", 32'({pcWrite, irWrite, mem_req, mem_we, link_write}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; mem_ready = 1'b0; ref_ret = 0;
    #1;
    chk("midreset_state", 32'(state), 32'd0);
    chk("midreset_mem_req", 32'(mem_req), 32'd1);

    run_instr(4'h3, 1'b0, 0, 0, 0);

`ifdef PC_SEQ_WDOG_EN
    c0 = cyc;
    e = '{kind: 2, cyc: c0 + int'(TIMEOUT), src: 3'd0, link: 1'b0, we_n: 0, ret: -1};
    q.push_back(e);
    for (int i = 0; i < int'(TIMEOUT); i++) drive(1'b0, 4'($urandom), 1'($urandom));
    #1;
    chk("wdog_state", 32'(state), 32'd4);
    chk("wdog_fault", 32'(fault), 32'd1);
    do_reset();
    chk("wdog_fault_cleared", 32'(fault), 32'd0);
`else
    for (int i = 0; i < 100; i++) drive(1'b0, 4'($urandom), 1'($urandom));
    #1;
    chk("nowdog_state", 32'(state), 32'd0);
    chk("nowdog_fault", 32'(fault), 32'd0);
    chk("nowdog_halted", 32'(halted), 32'd0);
    chk("nowdog_mem_req", 32'(mem_req), 32'd1);
`endif

    @(posedge clock); #1;
    @(posedge clock); #1;
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
